// File: rtl/router_port_fifo_if.sv
// Read/write handshake bundle between a port FIFO and the arbiters that fill and drain it.
interface router_port_fifo_if #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned ADDR_W = 3
) ();
  logic              write;
  logic [WIDTH-1:0]  din;
  logic              read;
  logic [WIDTH-1:0]  dout;
  logic              empty;
  logic              almost_empty;
  logic              full;
  logic              almost_full;
  logic [ADDR_W:0]   count;
  logic              overflow;
  logic              underflow;

  // Arbiter side: issues write/read requests and watches the status flags.
  modport master (
    output write, din, read,
    input  dout, empty, almost_empty, full, almost_full, count, overflow, underflow
  );

  // FIFO side.
  modport slave (
    input  write, din, read,
    output dout, empty, almost_empty, full, almost_full, count, overflow, underflow
  );
endinterface

// File: rtl/router_port_fifo.sv
// Input-port flit buffer: registered read data, count-derived status flags, and
// sticky overflow/underflow error bits.
module router_port_fifo #(
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned ADDR_W   = 3,
  parameter int unsigned AF_LEVEL = 7,
  parameter int unsigned AE_LEVEL = 1
) (
  input  logic               clk,
  input  logic               reset,
  router_port_fifo_if.slave  bus
);

  logic [WIDTH-1:0]  mem [DEPTH];
  logic [ADDR_W-1:0] wptr;
  logic [ADDR_W-1:0] rptr;
  logic [ADDR_W:0]   cnt;
  logic [WIDTH-1:0]  doutQ;
  logic              ovfQ;
  logic              udfQ;
  logic              isFull;
  logic              isEmpty;
  logic              wrOk;
  logic              rdOk;

  // Full/empty come from the occupancy count, so pointer wrap needs no extra bit.
  assign isFull  = (cnt == (ADDR_W+1)'(DEPTH));
  assign isEmpty = (cnt == '0);
  assign wrOk    = bus.write & ~isFull;
  assign rdOk    = bus.read & ~isEmpty;

  always_ff @(posedge clk) begin
    if (!reset) begin
      wptr  <= '0;
      rptr  <= '0;
      cnt   <= '0;
      doutQ <= '0;
      ovfQ  <= 1'b0;
      udfQ  <= 1'b0;
    end else begin
      if (wrOk) wptr <= wptr + ADDR_W'(1);
      if (rdOk) rptr <= rptr + ADDR_W'(1);
      // Zero on idle cycles so a valid flit is never presented twice.
      doutQ <= rdOk ? mem[rptr] : '0;
      case ({wrOk, rdOk})
        2'b10:   cnt <= cnt + (ADDR_W+1)'(1);
        2'b01:   cnt <= cnt - (ADDR_W+1)'(1);
        default: cnt <= cnt;
      endcase
      if (bus.write && isFull)  ovfQ <= 1'b1;
      if (bus.read  && isEmpty) udfQ <= 1'b1;
    end
  end

  // Storage array carries no reset; only occupancy state is cleared.
  always_ff @(posedge clk) begin
    if (reset && wrOk) mem[wptr] <= bus.din;
  end

  assign bus.dout         = doutQ;
  assign bus.count        = cnt;
  assign bus.overflow     = ovfQ;
  assign bus.underflow    = udfQ;
  assign bus.empty        = isEmpty;
  assign bus.full         = isFull;
  assign bus.almost_empty = (cnt <= (ADDR_W+1)'(AE_LEVEL));
  assign bus.almost_full  = (cnt >= (ADDR_W+1)'(AF_LEVEL));

endmodule

// File: doc/router_port_fifo.md
Name: router_port_fifo

Overview:
Input-port flit buffer for the linear E/W/L router. It is the storage on the other end of the arbiter's read/write handshake. The neighbour's (or local injector's) arbiter writes flits in using write and full/almost_full. This router's arbiter drains flits using read and empty/almost_empty. One instance per port (E, W, L); flits are WIDTH bits, bit0 = valid, bits[2:1] = destination IP.

Parameters:
WIDTH, 16, flit width; bit0 is the valid flag.
DEPTH, 8, number of flit entries; must be a power of two.
ADDR_W, 3, log2(DEPTH); pointer width.
AF_LEVEL, 7, almost_full asserted when count >= AF_LEVEL.
AE_LEVEL, 1, almost_empty asserted when count <= AE_LEVEL.

Ports:
clk  input  1  rising-edge clock.
reset  input  1  synchronous, active-low reset, sampled on clk rising edge.
write  input  1  write request from the upstream arbiter (writeE/W/L).
din  input  WIDTH  flit to store; stored as-is, including bit0.
read  input  1  read request from the local arbiter (readE/W/L).
dout  output  WIDTH  registered read data; valid for exactly one cycle after an accepted read.
empty  output  1  count == 0.
almost_empty  output  1  count <= AE_LEVEL (also 1 when empty).
full  output  1  count == DEPTH.
almost_full  output  1  count >= AF_LEVEL (also 1 when full).
count  output  ADDR_W+1  current occupancy, 0..DEPTH.
overflow  output  1  sticky; set by a write attempted while full.
underflow  output  1  sticky; set by a read attempted while empty.

Behaviour:
- All state updates on clk rising edge. reset==0 forces the following:
  - wptr = 0, rptr = 0, count = 0;
  - dout = 0, overflow = 0, underflow = 0;
  - empty = 1, almost_empty = 1, full = 0, almost_full = 0.
- Memory contents are not reset.
- Status flags are combinational decodes of the registered count. They change in the cycle after the causing edge, with no same-cycle bypass.
- Write accept: wr_ok = write & ~full.
  - On wr_ok: mem[wptr] <= din; wptr <= wptr+1, wrapping modulo DEPTH.
- Read accept: rd_ok = read & ~empty.
  - On rd_ok: dout <= mem[rptr]; rptr <= rptr+1, wrapping modulo DEPTH.
- Read latency is 1 cycle: a flit read at edge N is on dout during cycle N..N+1 only.
- On any edge without rd_ok, dout <= 0. This gives bit0 = 0, so the arbiter never sees a stale or duplicate valid flit.
- Count update:
  - wr_ok & ~rd_ok: count+1.
  - rd_ok & ~wr_ok: count-1.
  - both or neither: count unchanged.
- Simultaneous read+write when 0 < count < DEPTH: both are accepted; count is unchanged; pointers both advance.
- Write while full: dropped, even if read is also asserted (full is evaluated before the read). overflow <= 1, held until reset. Memory and wptr are unchanged.
- Read while empty: ignored, even if write is also asserted; the write is still accepted. dout <= 0; underflow <= 1, held until reset.
- Wrap-around: pointers are ADDR_W bits and roll over naturally. full/empty come from count, not from pointer compare.
- Reset asserted mid-stream discards all stored flits. The next cycle shows empty = 1 and dout = 0 regardless of read/write that cycle.
- The FIFO does not inspect or filter din[0]. Upstream writes only valid flits; invalid flits are stored as data if written.
- Flag timing matches the arbiter's registered read_able/wrt_able logic:
  - almost_empty & read means the last flit is being taken;
  - almost_full & write means the last slot is being filled.

Test Plan:
1. Reset then idle: hold reset=0 for 2 cycles, release -> empty=1, almost_empty=1, full=0, count=0, dout=16'h0000, overflow=0, underflow=0.
2. Fill and drain order: write 16'h0003, 16'h0005, ... (8 flits, bit0=1), then read 8 times -> count steps 0..8 then 8..0. almost_full rises at count=7, full at 8. dout returns the flits in order, each for one cycle, with dout=0 between non-read cycles.
3. Overflow: with count=8, assert write with din=16'h0007 -> count stays 8, overflow=1 sticky. A subsequent read returns the original first flit, not 16'h0007.
4. Underflow with concurrent write: empty FIFO, assert read and write (din=16'h0003) in the same cycle -> underflow=1, dout=0 next cycle, count=1. Next read gives dout=16'h0003.
5. Wrap and steady state: preload 4 flits, then read+write every cycle for 20 cycles with an incrementing payload -> count stays 4. Output order matches input order across pointer wrap; no flags toggle.
6. Reset mid-operation: count=5, pull reset=0 for one cycle while read=1 -> next cycle count=0, empty=1, dout=0. A following write/read pair returns only the new flit.
